// File: rtl/repeat_seq_ctrl_pkg.sv
// Shared types and power-up configuration for the repeat-N sequence controller.
//   state_t  : controller FSM encoding (IDLE, RUN, PAUSE)
//   DEF_*    : configuration loaded by reset (sequence 1..7, each held 3 cycles, wrapping)
package repeat_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int   DEF_LO   = 1;
  localparam int   DEF_HI   = 7;
  localparam int   DEF_REP  = 3;
  localparam logic DEF_WRAP = 1'b1;

endpackage

// File: rtl/repeat_seq_ctrl_tick.sv
// repeat_tick: repeat counter for the value currently shown by the controller.
// rcnt runs 1..rep; 'last' flags the final cycle of the current value.
// Ports:
//   clk   in  1   clock
//   rst   in  1   synchronous active-high reset (rcnt=1)
//   clr   in  1   restart at the first cycle of a value (rcnt=1); wins over en
//   en    in  1   count one held cycle; wraps back to 1 after the last one
//   rep   in  RW  cycles each value is held (never 0 while running)
//   last  out 1   rcnt==rep
module repeat_tick #(
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [RW-1:0] rep,
  output logic          last
);

  localparam logic [RW-1:0] ONE = RW'(1);

  logic [RW-1:0] rcnt_q;
  logic [RW-1:0] rcnt_d;

  assign last = (rcnt_q == rep);

  // rcnt is 1-based, so "cleared" means back at the first cycle of a value;
  // that way a fresh start needs no extra load path.
  always_comb begin
    rcnt_d = rcnt_q;
    if (clr) begin
      rcnt_d = ONE;
    end else if (en) begin
      rcnt_d = last ? ONE : rcnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= ONE;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end

endmodule

// File: rtl/repeat_seq_ctrl.sv
// repeat_seq_ctrl: controller for the stepped repeat-N counter. Each value in
// [lo..hi] is held for rep RUN cycles before advancing; one-shot or wrapping.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_valid/ready   config handshake; ready only in IDLE
//   cfg_lo/hi/rep/wrap config payload (checked: lo<=hi, rep!=0)
//   start, pause, stop sequencing controls (pause is a level)
//   count             current value (registered)
//   step              pulse on each cycle count takes a new value
//   busy              RUN or PAUSE
//   done              pulse when a one-shot sequence finishes
//   err               pulse for a rejected config
module repeat_seq_ctrl
  import repeat_seq_pkg::*;
#(
  parameter int W  = 3,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [W-1:0]  cfg_lo,
  input  logic [W-1:0]  cfg_hi,
  input  logic [RW-1:0] cfg_rep,
  input  logic          cfg_wrap,
  input  logic          start,
  input  logic          pause,
  input  logic          stop,
  output logic [W-1:0]  count,
  output logic          step,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          wrap_q, wrap_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          tick_clr;
  logic          tick_en;
  logic          tick_last;
  logic          cfg_ok;

  repeat_tick #(
    .RW(RW)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .rep  (rep_q),
    .last (tick_last)
  );

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == PAUSE);
  assign count     = count_q;
  assign step      = step_q;
  assign done      = done_q;
  assign err       = err_q;

  assign cfg_ok = (cfg_lo <= cfg_hi) && (cfg_rep != '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    rep_d    = rep_q;
    wrap_d   = wrap_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tick_clr = 1'b0;
    tick_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A config handshake takes the cycle; a simultaneous start is dropped.
        if (cfg_valid) begin
          if (cfg_ok) begin
            lo_d   = cfg_lo;
            hi_d   = cfg_hi;
            rep_d  = cfg_rep;
            wrap_d = cfg_wrap;
          end else begin
            err_d = 1'b1;
          end
        end else if (start) begin
          state_d  = RUN;
          count_d  = lo_q;
          tick_clr = 1'b1;
          step_d   = 1'b1;
        end
      end

      RUN: begin
        if (stop) begin
          state_d  = IDLE;
          count_d  = '0;
          tick_clr = 1'b1;
        end else if (pause) begin
          // The pausing cycle itself is not counted: rcnt holds.
          state_d = PAUSE;
        end else begin
          tick_en = 1'b1;
          if (tick_last) begin
            // Compare against hi rather than relying on overflow, so hi=2**W-1 is safe.
            if (count_q < hi_q) begin
              count_d = count_q + 1'b1;
              step_d  = 1'b1;
            end else if (wrap_q) begin
              count_d = lo_q;
              step_d  = 1'b1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      PAUSE: begin
        if (stop) begin
          state_d  = IDLE;
          count_d  = '0;
          tick_clr = 1'b1;
        end else if (!pause) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      lo_q    <= W'(DEF_LO);
      hi_q    <= W'(DEF_HI);
      rep_q   <= RW'(DEF_REP);
      wrap_q  <= DEF_WRAP;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rep_q   <= rep_d;
      wrap_q  <= wrap_d;
      step_q  <= step_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_repeat_seq_ctrl.sv
// Directed bench for repeat_seq_ctrl. Inputs change and outputs are sampled
// 1 ns after each rising edge; "cycle k" is the interval after edge k.
module tb_repeat_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_lo;
  logic [2:0] cfg_hi;
  logic [1:0] cfg_rep;
  logic       cfg_wrap;
  logic       start;
  logic       pause;
  logic       stop;
  logic [2:0] count;
  logic       step;
  logic       busy;
  logic       done;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  repeat_seq_ctrl #(.W(3), .RW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .cfg_rep   (cfg_rep),
    .cfg_wrap  (cfg_wrap),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .count     (count),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_valid = 1'b0;
    cfg_lo    = 3'd0;
    cfg_hi    = 3'd0;
    cfg_rep   = 2'd0;
    cfg_wrap  = 1'b0;
    start     = 1'b0;
    pause     = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Leaves the bench in cycle 1 of the run (first value showing).
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (count !== 3'd0 || step !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        busy !== 1'b0 || cfg_ready !== 1'b1) begin
      $display("FAIL reset: got count=%0d step=%0d done=%0d err=%0d busy=%0d ready=%0d expected 0 0 0 0 0 1",
               count, step, done, err, busy, cfg_ready);
      miscompares++;
    end
    rst = 1'b0;
    $display("reset released: count=%0d busy=%0d ready=%0d", count, busy, cfg_ready);
  endtask

  // Defaults: 1,1,1,2,2,2..7,7,7 then wraps to 1; step on each new value.
  task automatic test_defaults();
    logic [2:0] exp_c;
    logic       exp_s;
    do_start();
    for (int i = 0; i < 27; i++) begin
      exp_c = 3'((i / 3) % 7 + 1);
      exp_s = (i % 3 == 0);
      vectors++;
      if (count !== exp_c || step !== exp_s || busy !== 1'b1 || done !== 1'b0) begin
        $display("FAIL defaults[%0d]: got count=%0d step=%0d busy=%0d done=%0d expected %0d %0d 1 0",
                 i, count, step, busy, done, exp_c, exp_s);
        miscompares++;
      end
      tick();
    end
    do_stop();
    $display("defaults: 27 cycles checked, stopped count=%0d", count);
  endtask

  // lo=2 hi=4 rep=2 one-shot: 2,2,3,3,4,4 then done, count holds 4.
  task automatic test_oneshot();
    logic [2:0] exp_c;
    cfg_valid = 1'b1; cfg_lo = 3'd2; cfg_hi = 3'd4; cfg_rep = 2'd2; cfg_wrap = 1'b0;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      $display("FAIL oneshot_ready: got %0d expected 1", cfg_ready);
      miscompares++;
    end
    tick();
    cfg_valid = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      $display("FAIL oneshot_cfg_err: got %0d expected 0", err);
      miscompares++;
    end
    do_start();
    for (int i = 0; i < 6; i++) begin
      exp_c = 3'(2 + i / 2);
      vectors++;
      if (count !== exp_c || step !== (i % 2 == 0) || done !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL oneshot[%0d]: got count=%0d step=%0d done=%0d busy=%0d expected %0d %0d 0 1",
                 i, count, step, done, busy, exp_c, (i % 2 == 0));
        miscompares++;
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 3'd4 || step !== 1'b0) begin
      $display("FAIL oneshot_done: got done=%0d busy=%0d count=%0d step=%0d expected 1 0 4 0",
               done, busy, count, step);
      miscompares++;
    end
    tick();
    vectors++;
    if (done !== 1'b0 || count !== 3'd4 || cfg_ready !== 1'b1) begin
      $display("FAIL oneshot_after: got done=%0d count=%0d ready=%0d expected 0 4 1",
               done, count, cfg_ready);
      miscompares++;
    end
    $display("oneshot: finished at count=%0d", count);
  endtask

  // Rejected configs pulse err for one cycle and leave the defaults in place.
  task automatic test_bad_cfg();
    do_reset();
    cfg_valid = 1'b1; cfg_lo = 3'd5; cfg_hi = 3'd3; cfg_rep = 2'd2; cfg_wrap = 1'b0;
    tick();
    cfg_valid = 1'b0;
    vectors++;
    if (err !== 1'b1) begin
      $display("FAIL bad_lo_hi_err: got %0d expected 1", err);
      miscompares++;
    end
    tick();
    vectors++;
    if (err !== 1'b0) begin
      $display("FAIL bad_lo_hi_err_pulse: got %0d expected 0", err);
      miscompares++;
    end
    cfg_valid = 1'b1; cfg_lo = 3'd2; cfg_hi = 3'd6; cfg_rep = 2'd0; cfg_wrap = 1'b0;
    tick();
    cfg_valid = 1'b0;
    vectors++;
    if (err !== 1'b1) begin
      $display("FAIL bad_rep_err: got %0d expected 1", err);
      miscompares++;
    end
    do_start();
    vectors++;
    if (err !== 1'b0 || count !== 3'd1) begin
      $display("FAIL bad_cfg_run_start: got err=%0d count=%0d expected 0 1", err, count);
      miscompares++;
    end
    for (int i = 1; i < 22; i++) tick();
    // 21 cycles into the run the default sequence has wrapped back to 1.
    vectors++;
    if (count !== 3'd1 || step !== 1'b1) begin
      $display("FAIL bad_cfg_run_wrap: got count=%0d step=%0d expected 1 1", count, step);
      miscompares++;
    end
    do_stop();
    $display("bad_cfg: two rejects, default run intact");
  endtask

  // pause high during cycles 5..8 (2nd cycle of value 2): value 2 spans cycles 4..11.
  task automatic test_pause();
    logic [2:0] exp_c;
    logic       exp_s;
    do_start();
    for (int i = 1; i <= 12; i++) begin
      pause = (i >= 5 && i <= 8);
      exp_c = (i <= 3) ? 3'd1 : (i <= 11) ? 3'd2 : 3'd3;
      exp_s = (i == 1 || i == 4 || i == 12);
      vectors++;
      if (count !== exp_c || step !== exp_s || busy !== 1'b1) begin
        $display("FAIL pause[%0d]: got count=%0d step=%0d busy=%0d expected %0d %0d 1",
                 i, count, step, busy, exp_c, exp_s);
        miscompares++;
      end
      tick();
    end
    pause = 1'b0;
    do_stop();
    $display("pause: value 2 held across pause, advanced to 3 on cycle 12");
  endtask

  task automatic test_stop_and_reset();
    do_start();
    repeat (4) tick();
    stop = 1'b1; pause = 1'b1;
    tick();
    stop = 1'b0; pause = 1'b0;
    vectors++;
    if (count !== 3'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || step !== 1'b0) begin
      $display("FAIL stop_pause: got count=%0d busy=%0d ready=%0d step=%0d expected 0 0 1 0",
               count, busy, cfg_ready, step);
      miscompares++;
    end
    // stop from PAUSE
    do_start();
    pause = 1'b1;
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0; pause = 1'b0;
    vectors++;
    if (count !== 3'd0 || busy !== 1'b0) begin
      $display("FAIL stop_from_pause: got count=%0d busy=%0d expected 0 0", count, busy);
      miscompares++;
    end
    // reset mid-run restores default config
    cfg_valid = 1'b1; cfg_lo = 3'd2; cfg_hi = 3'd5; cfg_rep = 2'd1; cfg_wrap = 1'b0;
    tick();
    cfg_valid = 1'b0;
    do_start();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (count !== 3'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || step !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0) begin
      $display("FAIL reset_midrun: got count=%0d busy=%0d ready=%0d step=%0d done=%0d err=%0d expected 0 0 1 0 0 0",
               count, busy, cfg_ready, step, done, err);
      miscompares++;
    end
    rst = 1'b0;
    do_start();
    repeat (3) tick();
    vectors++;
    if (count !== 3'd2) begin
      $display("FAIL reset_defaults_restored: got count=%0d expected 2", count);
      miscompares++;
    end
    do_stop();
    $display("stop/reset: aborts returned to IDLE");
  endtask

  task automatic test_busy_cfg();
    do_start();
    cfg_valid = 1'b1; cfg_lo = 3'd7; cfg_hi = 3'd7; cfg_rep = 2'd1; cfg_wrap = 1'b1;
    start = 1'b1;
    vectors++;
    if (cfg_ready !== 1'b0) begin
      $display("FAIL busy_ready: got %0d expected 0", cfg_ready);
      miscompares++;
    end
    repeat (2) tick();
    cfg_valid = 1'b0; start = 1'b0;
    // cycle 3: still the first value, start did not restart anything
    vectors++;
    if (count !== 3'd1 || step !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
      $display("FAIL busy_ignored: got count=%0d step=%0d busy=%0d err=%0d expected 1 0 1 0",
               count, step, busy, err);
      miscompares++;
    end
    tick();
    vectors++;
    if (count !== 3'd2 || step !== 1'b1) begin
      $display("FAIL busy_no_load: got count=%0d step=%0d expected 2 1", count, step);
      miscompares++;
    end
    do_stop();
    // cfg and start in the same IDLE cycle: cfg wins, no run starts
    cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || err !== 1'b0 || count !== 3'd0) begin
      $display("FAIL cfg_beats_start: got busy=%0d err=%0d count=%0d expected 0 0 0", busy, err, count);
      miscompares++;
    end
    // lo=hi=7, rep=1, wrap: constant 7 with step every cycle
    do_start();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (count !== 3'd7 || step !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        $display("FAIL single_value[%0d]: got count=%0d step=%0d busy=%0d done=%0d expected 7 1 1 0",
                 i, count, step, busy, done);
        miscompares++;
      end
      tick();
    end
    do_stop();
    $display("busy_cfg: stalls honoured, lo=hi=7 rep=1 steps every cycle");
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_defaults();
    test_oneshot();
    test_bad_cfg();
    test_pause();
    test_stop_and_reset();
    test_busy_cfg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
